// File: rtl/cpu_io_pkg.sv
// Shared constants for the MC6809 I/O responder:
// register offsets, interrupt bit indices, watchdog states.
package cpu_io_pkg;

   localparam logic [3:0] OFF_IEN   = 4'h0;
   localparam logic [3:0] OFF_IPEND = 4'h1;
   localparam logic [3:0] OFF_WDOG  = 4'h2;
   localparam logic [3:0] OFF_TPER  = 4'h3;
   localparam logic [3:0] OFF_L0    = 4'h4;
   localparam logic [3:0] OFF_L1    = 4'h5;
   localparam logic [3:0] OFF_L2    = 4'h6;
   localparam logic [3:0] OFF_L3    = 4'h7;
   localparam logic [3:0] OFF_INP   = 4'h8;
   localparam logic [3:0] OFF_FCNT  = 4'h9;

   localparam int BIT_IRQ  = 0;
   localparam int BIT_FIRQ = 1;
   localparam int BIT_NMI  = 2;

   typedef enum logic {
      WD_RUN  = 1'b0,
      WD_FIRE = 1'b1
   } wd_state_t;

endpackage

// File: rtl/cpu_io_timer.sv
// FIRQ timer: prescaler plus tick counter compared against
// the programmed period; emits a one-clk expiry pulse.
module cpu_io_timer #(
   parameter int PRESCALE = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tper,
   input  logic       tper_wr,
   output logic       expire
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] presc;
   logic [7:0]    tick;
   logic          wrap;
   logic          hit;

   assign wrap = (presc == PW'(PRESCALE - 1));
   assign hit  = ((tick + 8'd1) == tper);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc  <= '0;
         tick   <= '0;
         expire <= 1'b0;
      end else begin
         expire <= 1'b0;
         if (tper_wr || (tper == 8'd0)) begin
            presc <= '0;
            tick  <= '0;
         end else if (wrap) begin
            presc <= '0;
            if (hit) begin
               tick   <= '0;
               expire <= 1'b1;
            end else begin
               tick <= tick + 8'd1;
            end
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: rtl/cpu_io_responder.sv
// MC6809 bus-side I/O responder: 16-byte window with interrupt,
// timer, watchdog, output latch and input port registers.
module cpu_io_responder
   import cpu_io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'h5000,
   parameter int          PRESCALE    = 256,
   parameter int          WDOG_FRAMES = 8,
   parameter int          WDOG_PULSE  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vma,
   input  logic        rw,
   input  logic [15:0] address,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        sel,
   output logic        irq,
   output logic        firq,
   output logic        nmi,
   input  logic        vblank,
   input  logic        ext_nmi,
   input  logic [7:0]  in_port,
   output logic [31:0] out_latch,
   output logic        wdog_rst
);

   localparam int FW = $clog2(WDOG_FRAMES + 1);
   localparam int PW = $clog2(WDOG_PULSE + 1);

   logic [3:0]      off;
   logic            vma_q;
   logic            stb;
   logic            wr_stb;
   logic            rd_stb;
   logic            we_ien;
   logic            we_ipend;
   logic            we_wdog;
   logic            we_tper;
   logic [3:0]      we_lat;
   logic [7:0]      rdata;

   logic            vb_m, vb_s, vb_q;
   logic            en_m, en_s, en_q;
   logic [7:0]      inp_m, inp_s;
   logic            vb_rise;
   logic            nmi_rise;

   logic [2:0]      ien;
   logic [2:0]      ipend;
   logic [2:0]      ipend_set;
   logic [2:0]      ipend_clr;
   logic [7:0]      tper;
   logic [3:0][7:0] lat;
   logic [7:0]      fcnt;
   logic            expire;

   wd_state_t       wd_state;
   wd_state_t       wd_next;
   logic [FW-1:0]   wd_cnt;
   logic [PW-1:0]   wd_pcnt;

   assign off    = address[3:0];
   assign sel    = vma & (address[15:4] == BASE_ADDR[15:4]);
   assign stb    = sel & ~vma_q;
   assign wr_stb = stb & ~rw;
   assign rd_stb = stb & rw;

   // vma_q resets high so a bus cycle cut by reset never strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vma_q <= 1'b1;
      else        vma_q <= vma;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vb_m  <= 1'b0;
         vb_s  <= 1'b0;
         vb_q  <= 1'b0;
         en_m  <= 1'b0;
         en_s  <= 1'b0;
         en_q  <= 1'b0;
         inp_m <= '0;
         inp_s <= '0;
      end else begin
         vb_m  <= vblank;
         vb_s  <= vb_m;
         vb_q  <= vb_s;
         en_m  <= ext_nmi;
         en_s  <= en_m;
         en_q  <= en_s;
         inp_m <= in_port;
         inp_s <= inp_m;
      end
   end

   assign vb_rise  = vb_s & ~vb_q;
   assign nmi_rise = en_s & ~en_q;

   always_comb begin
      we_ien   = 1'b0;
      we_ipend = 1'b0;
      we_wdog  = 1'b0;
      we_tper  = 1'b0;
      we_lat   = '0;
      if (wr_stb) begin
         unique case (1'b1)
            (off == OFF_IEN):   we_ien    = 1'b1;
            (off == OFF_IPEND): we_ipend  = 1'b1;
            (off == OFF_WDOG):  we_wdog   = 1'b1;
            (off == OFF_TPER):  we_tper   = 1'b1;
            (off == OFF_L0):    we_lat[0] = 1'b1;
            (off == OFF_L1):    we_lat[1] = 1'b1;
            (off == OFF_L2):    we_lat[2] = 1'b1;
            (off == OFF_L3):    we_lat[3] = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = 8'hFF;
      case (off)
         OFF_IEN:   rdata = {5'd0, ien};
         OFF_IPEND: rdata = {5'd0, ipend};
         OFF_WDOG:  rdata = 8'h00;
         OFF_TPER:  rdata = tper;
         OFF_L0:    rdata = lat[0];
         OFF_L1:    rdata = lat[1];
         OFF_L2:    rdata = lat[2];
         OFF_L3:    rdata = lat[3];
         OFF_INP:   rdata = inp_s;
         OFF_FCNT:  rdata = fcnt;
         default:   rdata = 8'hFF;
      endcase
   end

   always_comb begin
      ipend_set           = '0;
      ipend_set[BIT_IRQ]  = vb_rise;
      ipend_set[BIT_FIRQ] = expire;
      ipend_set[BIT_NMI]  = nmi_rise;
      ipend_clr           = we_ipend ? cpu_dout[2:0] : 3'd0;
   end

   cpu_io_timer #(
      .PRESCALE (PRESCALE)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .tper    (tper),
      .tper_wr (we_tper),
      .expire  (expire)
   );

   // set is OR-ed after the clear so a coincident set survives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ien     <= '0;
         ipend   <= '0;
         tper    <= '0;
         lat     <= '0;
         fcnt    <= '0;
         cpu_din <= 8'hFF;
         irq     <= 1'b0;
         firq    <= 1'b0;
         nmi     <= 1'b0;
      end else begin
         if (we_ien)  ien  <= cpu_dout[2:0];
         if (we_tper) tper <= cpu_dout;
         for (int i = 0; i < 4; i++) begin
            if (we_lat[i]) lat[i] <= cpu_dout;
         end
         if (vb_rise) fcnt <= fcnt + 8'd1;
         if (rd_stb)  cpu_din <= rdata;
         ipend <= (ipend & ~ipend_clr) | ipend_set;
         irq   <= ipend[BIT_IRQ]  & ien[BIT_IRQ];
         firq  <= ipend[BIT_FIRQ] & ien[BIT_FIRQ];
         nmi   <= ipend[BIT_NMI]  & ien[BIT_NMI];
      end
   end

   assign out_latch = lat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_state <= WD_RUN;
         wd_cnt   <= '0;
         wd_pcnt  <= '0;
      end else begin
         wd_state <= wd_next;
         unique case (wd_state)
            WD_RUN: begin
               wd_pcnt <= '0;
               if (wd_cnt == FW'(WDOG_FRAMES)) wd_cnt <= '0;
               else if (we_wdog)               wd_cnt <= '0;
               else if (vb_rise)               wd_cnt <= wd_cnt + FW'(1);
            end
            WD_FIRE: begin
               wd_cnt  <= '0;
               wd_pcnt <= wd_pcnt + PW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wd_next = wd_state;
      unique case (wd_state)
         WD_RUN:  if (wd_cnt == FW'(WDOG_FRAMES))
                     wd_next = WD_FIRE;
         WD_FIRE: if (wd_pcnt == PW'(WDOG_PULSE - 1))
                     wd_next = WD_RUN;
         default: wd_next = WD_RUN;
      endcase
   end

   always_comb begin
      wdog_rst = 1'b0;
      if (wd_state == WD_FIRE) wdog_rst = 1'b1;
   end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder: register table plus
// interrupt, timer, watchdog and reset-mid-access sequences.
module tb_cpu_io_responder;

   localparam logic [15:0] B = 16'h5000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vma;
   logic        rw;
   logic [15:0] address;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        sel;
   logic        irq;
   logic        firq;
   logic        nmi;
   logic        vblank;
   logic        ext_nmi;
   logic [7:0]  in_port;
   logic [31:0] out_latch;
   logic        wdog_rst;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int stb_cnt = 0;
   int nfr = 0;
   int fr_t[16];
   int wd_hi = 0;
   int wd_rises = 0;
   logic firq_d = 1'b0;
   logic wd_d = 1'b0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t vt[$];

   cpu_io_responder #(
      .BASE_ADDR   (B),
      .PRESCALE    (4),
      .WDOG_FRAMES (8),
      .WDOG_PULSE  (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vma       (vma),
      .rw        (rw),
      .address   (address),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .sel       (sel),
      .irq       (irq),
      .firq      (firq),
      .nmi       (nmi),
      .vblank    (vblank),
      .ext_nmi   (ext_nmi),
      .in_port   (in_port),
      .out_latch (out_latch),
      .wdog_rst  (wdog_rst)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #2;
      if (dut.stb) stb_cnt++;
   end

   always @(negedge clk) begin
      cyc++;
      if (firq && !firq_d && nfr < 16) begin
         fr_t[nfr] = cyc;
         nfr++;
      end
      firq_d = firq;
      if (wdog_rst) wd_hi++;
      if (wdog_rst && !wd_d) wd_rises++;
      wd_d = wdog_rst;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                            input int hold);
      @(negedge clk);
      address  = a;
      cpu_dout = d;
      rw       = 1'b0;
      vma      = 1'b1;
      repeat (hold) @(negedge clk);
      vma = 1'b0;
      rw  = 1'b1;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      address = a;
      rw      = 1'b1;
      vma     = 1'b1;
      repeat (2) @(negedge clk);
      d   = cpu_din;
      vma = 1'b0;
   endtask

   task automatic pulse_vb(input int hi, input int lo);
      vblank = 1'b1;
      repeat (hi) @(negedge clk);
      vblank = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic wait_sig(input string name, input logic lvl,
                           input int which);
      int w = 0;
      logic v;
      v = (which == 0) ? firq : wdog_rst;
      while (v !== lvl && w < 60) begin
         @(negedge clk);
         w++;
         v = (which == 0) ? firq : wdog_rst;
      end
      chk(name, {31'd0, v}, {31'd0, lvl});
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      int s0, r0, h0, n0;

      rst_n = 1'b0; vma = 1'b0; rw = 1'b1; address = '0;
      cpu_dout = '0; vblank = 1'b0; ext_nmi = 1'b0;
      in_port = 8'h5A;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_cpu_din", {24'd0, cpu_din}, 32'hFF);
      chk("rst_irqs", {29'd0, irq, firq, nmi}, 32'd0);
      chk("rst_latch", out_latch, 32'd0);
      chk("rst_wdog", {31'd0, wdog_rst}, 32'd0);

      s0 = stb_cnt;
      bus_write(B + 16'd5, 8'h3C, 4);
      @(negedge clk);
      chk("l1_strobes", stb_cnt - s0, 32'd1);
      chk("l1_latch", {24'd0, out_latch[15:8]}, 32'h3C);

      vt.push_back('{1'b0, B + 16'h8, 8'h5A});
      vt.push_back('{1'b0, B + 16'h0, 8'h00});
      vt.push_back('{1'b0, B + 16'h1, 8'h00});
      vt.push_back('{1'b0, B + 16'h3, 8'h00});
      vt.push_back('{1'b0, B + 16'h5, 8'h3C});
      vt.push_back('{1'b1, B + 16'h4, 8'h11});
      vt.push_back('{1'b1, B + 16'h6, 8'h22});
      vt.push_back('{1'b1, B + 16'h7, 8'h44});
      vt.push_back('{1'b0, B + 16'h4, 8'h11});
      vt.push_back('{1'b0, B + 16'h6, 8'h22});
      vt.push_back('{1'b0, B + 16'h7, 8'h44});
      vt.push_back('{1'b1, 16'h5105, 8'h77});
      vt.push_back('{1'b1, 16'h4005, 8'h77});
      vt.push_back('{1'b0, B + 16'h5, 8'h3C});
      vt.push_back('{1'b1, B + 16'hA, 8'h55});
      vt.push_back('{1'b0, B + 16'hA, 8'hFF});
      vt.push_back('{1'b0, B + 16'hC, 8'hFF});
      vt.push_back('{1'b0, B + 16'hF, 8'hFF});
      vt.push_back('{1'b1, B + 16'h2, 8'h99});
      vt.push_back('{1'b0, B + 16'h2, 8'h00});
      vt.push_back('{1'b1, B + 16'h0, 8'hFF});
      vt.push_back('{1'b0, B + 16'h0, 8'h07});
      vt.push_back('{1'b1, B + 16'h0, 8'h00});
      vt.push_back('{1'b0, B + 16'h0, 8'h00});
      vt.push_back('{1'b1, B + 16'h3, 8'h05});
      vt.push_back('{1'b0, B + 16'h3, 8'h05});
      vt.push_back('{1'b1, B + 16'h3, 8'h00});
      vt.push_back('{1'b0, B + 16'h1, 8'h00});
      vt.push_back('{1'b0, B + 16'h9, 8'h00});

      foreach (vt[i]) begin
         if (vt[i].wr) begin
            bus_write(vt[i].addr, vt[i].data, 2);
         end else begin
            bus_read(vt[i].addr, d);
            chk($sformatf("vec%0d_rd_%h", i, vt[i].addr),
                {24'd0, d}, {24'd0, vt[i].data});
         end
      end
      @(negedge clk);
      chk("latch_all", out_latch, 32'h44223C11);

      bus_write(B + 16'h0, 8'h01, 2);
      pulse_vb(4, 4);
      chk("vb_irq", {31'd0, irq}, 32'd1);
      bus_read(B + 16'h1, d);
      chk("vb_ipend", {24'd0, d}, 32'h01);

      @(negedge clk);
      vblank = 1'b1;
      repeat (2) @(negedge clk);
      address = B + 16'h1; cpu_dout = 8'h01; rw = 1'b0; vma = 1'b1;
      repeat (2) @(negedge clk);
      vma = 1'b0; rw = 1'b1;
      repeat (2) @(negedge clk);
      vblank = 1'b0;
      repeat (4) @(negedge clk);
      chk("set_wins_irq", {31'd0, irq}, 32'd1);
      bus_read(B + 16'h1, d);
      chk("set_wins_ipend", {24'd0, d}, 32'h01);
      bus_write(B + 16'h1, 8'h01, 2);
      chk("w1c_irq", {31'd0, irq}, 32'd0);
      bus_read(B + 16'h9, d);
      chk("fcnt_2", {24'd0, d}, 32'h02);

      bus_write(B + 16'h0, 8'h02, 2);
      bus_write(B + 16'h1, 8'h07, 2);
      n0 = nfr;
      bus_write(B + 16'h3, 8'h03, 2);
      for (int k = 0; k < 4; k++) begin
         wait_sig($sformatf("firq_rise%0d", k), 1'b1, 0);
         bus_write(B + 16'h1, 8'h02, 2);
      end
      chk("firq_count", {31'd0, (nfr - n0) >= 4}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("firq_period%0d", k),
             fr_t[n0 + k + 1] - fr_t[n0 + k], 32'd12);
      end
      bus_write(B + 16'h3, 8'h00, 2);
      bus_write(B + 16'h1, 8'h07, 2);
      bus_write(B + 16'h0, 8'h00, 2);

      bus_write(B + 16'h2, 8'h00, 2);
      r0 = wd_rises;
      h0 = wd_hi;
      repeat (7) pulse_vb(4, 4);
      chk("wdog_7_quiet", wd_rises - r0, 32'd0);
      pulse_vb(4, 4);
      wait_sig("wdog_fire", 1'b1, 1);
      bus_write(B + 16'h2, 8'h00, 2);
      wait_sig("wdog_release", 1'b0, 1);
      chk("wdog_rises", wd_rises - r0, 32'd1);
      chk("wdog_len", wd_hi - h0, 32'd16);
      for (int k = 0; k < 3; k++) begin
         bus_write(B + 16'h2, 8'h00, 2);
         repeat (7) pulse_vb(4, 4);
      end
      repeat (10) @(negedge clk);
      chk("wdog_kicked", wd_rises - r0, 32'd1);
      bus_read(B + 16'h9, d);
      chk("fcnt_31", {24'd0, d}, 32'd31);
      repeat (225) pulse_vb(2, 2);
      bus_read(B + 16'h9, d);
      chk("fcnt_wrap", {24'd0, d}, 32'h00);

      s0 = stb_cnt;
      @(negedge clk);
      address = B + 16'h4; cpu_dout = 8'hAA; rw = 1'b0; vma = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_latch", out_latch, 32'd0);
      chk("midrst_din", {24'd0, cpu_din}, 32'hFF);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vma = 1'b0; rw = 1'b1;
      @(negedge clk);
      chk("postrst_latch", out_latch, 32'd0);
      chk("postrst_strobes", stb_cnt - s0, 32'd0);
      bus_write(B + 16'h0, 8'h04, 2);
      ext_nmi = 1'b1;
      repeat (5) @(negedge clk);
      chk("nmi", {29'd0, irq, firq, nmi}, 32'd1);
      ext_nmi = 1'b0;
      bus_read(B + 16'h1, d);
      chk("nmi_ipend", {24'd0, d}, 32'h04);
      bus_read(B + 16'h8, d);
      chk("inp_after_rst", {24'd0, d}, 32'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
